// File: rtl/nts_engine_ctrl.sv
// Packet-sequencing controller for one NTS engine: chains NUM_STAGES start/done/error stages with a watchdog.
// Optional statistics counters are built when NTS_ENGINE_CTRL_STATS_EN is defined.
module nts_engine_ctrl #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned STAT_WIDTH     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_packet_available,
    input  logic                  i_fifo_empty,
    input  logic                  i_rx_overflow,
    output logic                  o_clear,
    output logic                  o_busy,
    output logic [NUM_STAGES-1:0] o_stage_start,
    input  logic [NUM_STAGES-1:0] i_stage_done,
    input  logic [NUM_STAGES-1:0] i_stage_error,
    output logic                  o_packet_discard,
    output logic [2:0]            o_error_code,
    output logic [2:0]            o_error_stage,
    input  logic [1:0]            i_stat_addr,
    output logic [STAT_WIDTH-1:0] o_stat_data
);

    localparam int unsigned IDXW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned WDW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_STAGES - 1);
    localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] CODE_BAD      = 3'd1;
    localparam logic [2:0] CODE_OVERFLOW = 3'd2;
    localparam logic [2:0] CODE_TIMEOUT  = 3'd3;

    typedef enum logic [2:0] {
        S_RESET,
        S_EMPTY,
        S_COPY,
        S_STAGE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q;
    logic [IDXW-1:0]       idx_q;
    logic [WDW-1:0]        wd_q;
    logic                  first_q;
    logic                  clear_q;
    logic                  busy_q;
    logic [NUM_STAGES-1:0] start_q;
    logic                  discard_q;
    logic [2:0]            code_q;
    logic [2:0]            estage_q;

    logic [IDXW-1:0] idx_inc;
    logic            cur_done;
    logic            cur_error;

    assign idx_inc   = idx_q + 1'b1;
    assign cur_done  = i_stage_done[idx_q];
    assign cur_error = i_stage_error[idx_q];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_RESET;
            idx_q     <= '0;
            wd_q      <= '0;
            first_q   <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= '0;
            discard_q <= 1'b0;
            code_q    <= '0;
            estage_q  <= '0;
        end else begin
            clear_q   <= 1'b0;
            start_q   <= '0;
            discard_q <= 1'b0;
            case (state_q)
                S_RESET: begin
                    clear_q <= 1'b1;
                    wd_q    <= '0;
                    idx_q   <= '0;
                    first_q <= 1'b0;
                    state_q <= S_EMPTY;
                end
                S_EMPTY: begin
                    if (i_packet_available && !i_fifo_empty) begin
                        busy_q   <= 1'b1;
                        code_q   <= '0;
                        estage_q <= '0;
                        state_q  <= S_COPY;
                    end
                end
                S_COPY: begin
                    if (i_rx_overflow) begin
                        code_q    <= CODE_OVERFLOW;
                        discard_q <= 1'b1;
                        state_q   <= S_ERR;
                    end else if (i_fifo_empty) begin
                        idx_q   <= '0;
                        wd_q    <= '0;
                        first_q <= 1'b1;
                        start_q <= NUM_STAGES'(1);
                        state_q <= S_STAGE;
                    end
                end
                S_STAGE: begin
                    first_q <= 1'b0;
                    // Handshake inputs are ignored in the cycle the start pulse is out.
                    if (!first_q && cur_error) begin
                        code_q    <= CODE_BAD;
                        estage_q  <= 3'(idx_q);
                        discard_q <= 1'b1;
                        state_q   <= S_ERR;
                    end else if (!first_q && cur_done) begin
                        if (idx_q == IDX_LAST) begin
                            discard_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            idx_q   <= idx_inc;
                            wd_q    <= '0;
                            first_q <= 1'b1;
                            start_q <= NUM_STAGES'(1) << idx_inc;
                        end
                    end else if (wd_q == WD_LAST) begin
                        code_q    <= CODE_TIMEOUT;
                        estage_q  <= 3'(idx_q);
                        discard_q <= 1'b1;
                        state_q   <= S_ERR;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_RESET;
                end
                default: begin
                    code_q    <= CODE_BAD;
                    discard_q <= 1'b1;
                    state_q   <= S_ERR;
                end
            endcase
        end
    end

    assign o_clear          = clear_q;
    assign o_busy           = busy_q;
    assign o_stage_start    = start_q;
    assign o_packet_discard = discard_q;
    assign o_error_code     = code_q;
    assign o_error_stage    = estage_q;

`ifdef NTS_ENGINE_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] cnt_q [4];
    logic [STAT_WIDTH-1:0] stat_q;

    // Counters advance in the discard cycle, indexed by the final error code.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            stat_q <= '0;
        end else begin
            if (state_q == S_DONE || state_q == S_ERR) begin
                cnt_q[code_q[1:0]] <= cnt_q[code_q[1:0]] + 1'b1;
            end
            stat_q <= cnt_q[i_stat_addr];
        end
    end

    assign o_stat_data = stat_q;
`else
    logic unused_stat_addr;
    assign unused_stat_addr = ^i_stat_addr;
    assign o_stat_data      = '0;
`endif

endmodule

// File: tb/tb_nts_engine_ctrl.sv
// Randomized bench for nts_engine_ctrl: per-packet outcome model plus stage responder with noise on other bits.
module tb_nts_engine_ctrl;

    localparam int unsigned NS = 4;
    localparam int unsigned T  = 16;
    localparam int unsigned SW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pkt_avail;
    logic          fifo_empty;
    logic          rx_ovf;
    logic          clear;
    logic          busy;
    logic [NS-1:0] start;
    logic [NS-1:0] done;
    logic [NS-1:0] err;
    logic          discard;
    logic [2:0]    ecode;
    logic [2:0]    estage;
    logic [1:0]    stat_addr;
    logic [SW-1:0] stat_data;

    always #5 clk = ~clk;

    nts_engine_ctrl #(
        .NUM_STAGES    (NS),
        .TIMEOUT_CYCLES(T),
        .STAT_WIDTH    (SW)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_packet_available(pkt_avail),
        .i_fifo_empty      (fifo_empty),
        .i_rx_overflow     (rx_ovf),
        .o_clear           (clear),
        .o_busy            (busy),
        .o_stage_start     (start),
        .i_stage_done      (done),
        .i_stage_error     (err),
        .o_packet_discard  (discard),
        .o_error_code      (ecode),
        .o_error_stage     (estage),
        .i_stat_addr       (stat_addr),
        .o_stat_data       (stat_data)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned resp[NS];
    bit          is_err[NS];
    bit          err_done[NS];
    int unsigned exp_cnt[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clear"}, clear, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_discard"}, discard, 0);
        check({tag, "_code"}, ecode, 0);
        check({tag, "_stage"}, estage, 0);
        check({tag, "_stat"}, stat_data, 0);
    endtask

    task automatic set_clean(input int unsigned lat);
        for (int s = 0; s < NS; s++) begin
            resp[s]     = lat;
            is_err[s]   = 1'b0;
            err_done[s] = 1'b0;
        end
    endtask

    task automatic run_packet(input bit ovf, input int unsigned copy_len);
        int unsigned exp_code, exp_stage, exp_starts;
        int unsigned n, exp_next, t_start, nstarts, cur;
        bit accepted, finished;

        exp_code = 0; exp_stage = 0; exp_starts = NS;
        if (ovf) begin
            exp_code = 2; exp_starts = 0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (resp[s] >= T) begin
                    exp_code = 3; exp_stage = s; exp_starts = s + 1; break;
                end
                if (is_err[s]) begin
                    exp_code = 1; exp_stage = s; exp_starts = s + 1; break;
                end
            end
        end

        pkt_avail = 1'b1; fifo_empty = 1'b0; rx_ovf = 1'b0;
        accepted = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            tick();
            if (busy) accepted = 1'b1;
        end
        check("accept", accepted, 1);
        pkt_avail = 1'b0;
        if (!accepted) begin
            fifo_empty = 1'b1;
            return;
        end
        check("accept_code_clr", ecode, 0);
        check("accept_stage_clr", estage, 0);

        for (int i = 0; i <= copy_len; i++) begin
            fifo_empty = (i == copy_len);
            rx_ovf     = ovf && (i == copy_len);
            if (i != copy_len) begin
                tick();
                check("copy_start_idle", start, 0);
            end
        end

        n = 0; exp_next = 1; nstarts = 0; cur = 0; t_start = 0; finished = 1'b0;
        for (int k = 0; k < NS * (T + 4) + 8 && !finished; k++) begin
            tick();
            n++;
            rx_ovf = 1'b0;
            if (start != '0) begin
                check("start_onehot", start, NS'(1) << nstarts);
                check("start_time", n, exp_next);
                cur     = (nstarts < NS) ? nstarts : NS - 1;
                nstarts++;
                t_start = n;
                exp_next = (resp[cur] >= T) ? n + T : n + resp[cur] + 1;
            end
            if (discard) begin
                check("discard_time", n, exp_next);
                check("discard_code", ecode, exp_code);
                check("discard_stage", estage, exp_stage);
                check("start_count", nstarts, exp_starts);
                finished = 1'b1;
            end
            done = NS'($urandom) & ~(NS'(1) << cur);
            err  = NS'($urandom) & ~(NS'(1) << cur);
            if (!finished && nstarts > 0) begin
                if (n == t_start) begin
                    done[cur] = 1'($urandom);
                    err[cur]  = 1'($urandom);
                end else if (resp[cur] < T && n == t_start + resp[cur]) begin
                    done[cur] = !is_err[cur] || err_done[cur];
                    err[cur]  = is_err[cur];
                end
            end
        end
        check("discard_seen", finished, 1);
        done = '0; err = '0;
        if (!finished) return;

        stat_addr = 2'(exp_code);
        exp_cnt[exp_code]++;
        tick();
        check("busy_drop", busy, 0);
        check("discard_single", discard, 0);
        tick();
        check("clear_pulse", clear, 1);
        check("code_hold", ecode, exp_code);
`ifdef NTS_ENGINE_CTRL_STATS_EN
        check("stat_count", stat_data, exp_cnt[exp_code]);
`else
        check("stat_zero", stat_data, 0);
`endif
        tick();
        check("clear_single", clear, 0);
    endtask

    task automatic reset_mid_stage1();
        bit seen, disc_seen, accepted;
        int unsigned t0;
        pkt_avail = 1'b1; fifo_empty = 1'b0; accepted = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            tick();
            if (busy) accepted = 1'b1;
        end
        check("rst_accept", accepted, 1);
        pkt_avail = 1'b0; fifo_empty = 1'b1;
        seen = 1'b0; t0 = 0;
        for (int unsigned k = 1; k < 40 && !seen; k++) begin
            tick();
            done = '0;
            if (start[0]) t0 = k;
            if (start[1]) seen = 1'b1;
            if (t0 != 0 && k == t0 + 3) done[0] = 1'b1;
        end
        done = '0;
        check("rst_saw_start1", seen, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        disc_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (discard) disc_seen = 1'b1;
        end
        check("midrst_no_discard", disc_seen, 0);
        check("midrst_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; pkt_avail = 1'b0; fifo_empty = 1'b1; rx_ovf = 1'b0;
        done = '0; err = '0; stat_addr = '0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("clear_after_reset", clear, 1);
        tick();
        check("clear_after_reset_single", clear, 0);

        set_clean(3);
        run_packet(1'b0, 2);
        set_clean(3);
        run_packet(1'b1, 0);
        set_clean(2);
        resp[2] = T + 2;
        run_packet(1'b0, 1);
        set_clean(2);
        is_err[1] = 1'b1; err_done[1] = 1'b1;
        run_packet(1'b0, 0);
        set_clean(3);
        reset_mid_stage1();
        set_clean(3);
        run_packet(1'b0, 0);
        set_clean(1);
        resp[0] = T - 1; resp[1] = T;
        run_packet(1'b0, 3);
        set_clean(1);
        resp[NS-1] = T - 1;
        run_packet(1'b0, 0);

        for (int p = 0; p < 40; p++) begin
            int unsigned pick;
            for (int s = 0; s < NS; s++) begin
                resp[s] = $urandom_range(1, 6);
                pick = $urandom_range(0, 15);
                if (pick == 0) resp[s] = T - 1;
                else if (pick == 1) resp[s] = T;
                else if (pick == 2) resp[s] = T + 2;
                is_err[s]   = ($urandom_range(0, 9) == 0);
                err_done[s] = 1'($urandom);
            end
            run_packet($urandom_range(0, 7) == 0, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
